fetch_unit: RTL and testbench

Instruction-fetch front end that produces the `pc`/`inst` pair consumed by the IF/ID pipeline register. It generates the sequential PC and issues one outstanding request at a time to instruction memory over a request/grant plus response valid/ready handshake. It holds a fetched instruction while the pipeline stalls (`hazard_i`) and redirects to a branch target on `flush_i`. When no instruction is ready, it presents a bubble (all-zero NOP).

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_slot.sv | 58 +++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states
//   INST_NOP      : bubble presented when no instruction is ready
//   PC_STEP       : sequential PC increment (bytes)
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_slot.sv
// One-entry holding register for a fetched {pc, instruction} pair.
//   clk, rst_n       : clock, asynchronous active-low reset
//   init             : synchronous return to reset contents
//   clear            : drop the held entry (contents kept, valid cleared)
//   load             : capture load_pc/load_inst (wins over consume)
//   consume          : downstream took the entry this edge
//   valid, pc, inst  : registered entry contents
module fetch_slot
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        clear,
    input  logic        load,
    input  logic        consume,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    // Occupancy flag: a load on the consume edge keeps the slot full (back-to-back)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (init || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (consume) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

    // Payload: pc/inst retained after consume so a stalled consumer sees stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            inst <= INST_NOP;
        end else if (init) begin
            pc   <= RESET_PC;
            inst <= INST_NOP;
        end else if (load && !clear) begin
            pc   <= load_pc;
            inst <= load_inst;
        end else begin
            pc   <= pc;
            inst <= inst;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register.
// One outstanding request to instruction memory (req/gnt, rvalid/rready).
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   start_i              : run enable; low synchronously clears the unit
//   hazard_i             : pipeline stall, presented instruction held
//   flush_i              : redirect to branch_target_i, beats hazard_i
//   imem_req_o/addr_o    : fetch request and its address
//   imem_gnt_i           : request accepted
//   imem_rvalid_i/rdata_i: response from memory (held until rready)
//   imem_rready_o        : response accept
//   pc_o, inst_o         : presented pair (inst_o is NOP when empty)
//   fetch_busy_o         : no instruction presented
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        hazard_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        imem_rready_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        fetch_busy_o
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic [31:0]  addr_r;
    logic         stale_r;
    logic         stale_next_s;
    logic         slot_valid_s;
    logic [31:0]  slot_pc_s;
    logic [31:0]  slot_inst_s;
    logic         consume_s;
    logic         rready_s;
    logic         resp_fire_s;
    logic         slot_load_s;
    logic         slot_clear_s;
    logic         slot_init_s;
    logic         active_s;

    assign active_s     = (state_r != ST_IDLE);
    assign consume_s    = slot_valid_s & ~hazard_i & ~flush_i;
    // DRAIN swallows a discarded response regardless of the slot
    assign rready_s     = (state_r == ST_DRAIN) | ~slot_valid_s | consume_s;
    assign resp_fire_s  = imem_rvalid_i & rready_s;
    assign slot_clear_s = flush_i & active_s;
    assign slot_init_s  = ~start_i;

    // Next-state, slot load and next fetch PC
    always_comb begin
        state_next_s = state_r;
        stale_next_s = 1'b0;
        slot_load_s  = 1'b0;
        pc_next_s    = pc_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A flush while waiting for grant marks the request stale; its response is drained
                if (imem_gnt_i) begin
                    if (!start_i || flush_i || stale_r) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else if (!start_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                    stale_next_s = stale_r | flush_i;
                end
            end
            ST_WAIT: begin
                if (resp_fire_s) begin
                    slot_load_s  = start_i & ~flush_i;
                    state_next_s = start_i ? ST_REQ : ST_IDLE;
                end else if (!start_i || flush_i) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_next_s = start_i ? ST_REQ : ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (!start_i) begin
            pc_next_s = RESET_PC;
        end else if (slot_clear_s) begin
            pc_next_s = branch_target_i;
        end else if (slot_load_s) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // FSM, fetch PC and request address; address latched on REQ entry so it stays stable until grant
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            stale_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            stale_r <= stale_next_s;
            if ((state_next_s == ST_REQ) && (state_r != ST_REQ)) begin
                addr_r <= pc_next_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    fetch_slot #(
        .RESET_PC (RESET_PC)
    ) u_slot (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .init      (slot_init_s),
        .clear     (slot_clear_s),
        .load      (slot_load_s),
        .consume   (consume_s),
        .load_pc   (pc_r),
        .load_inst (imem_rdata_i),
        .valid     (slot_valid_s),
        .pc        (slot_pc_s),
        .inst      (slot_inst_s)
    );

    assign imem_req_o    = (state_r == ST_REQ);
    assign imem_addr_o   = addr_r;
    assign imem_rready_o = rready_s;
    assign pc_o          = slot_pc_s;
    assign inst_o        = slot_valid_s ? slot_inst_s : INST_NOP;
    assign fetch_busy_o  = ~slot_valid_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/flush/start traffic against a memory model whose rdata = addr ^ KEY.
// The reference tracks only the program-order PC the next presented
// instruction must carry.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hazard;
    logic        flush;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rready;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        busy;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .start_i         (start),
        .hazard_i        (hazard),
        .flush_i         (flush),
        .branch_target_i (target),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_gnt_i      (gnt),
        .imem_rvalid_i   (rvalid),
        .imem_rdata_i    (rdata),
        .imem_rready_o   (rready),
        .pc_o            (pc),
        .inst_o          (inst),
        .fetch_busy_o    (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus requests for the next tick
    logic        drv_start  = 1'b0;
    logic        drv_hazard = 1'b0;
    logic        drv_flush  = 1'b0;
    logic [31:0] drv_target = 32'h0;
    int          gnt_mode   = 1;   // 0 random, 1 always, 2 never
    int          dly_min    = 0;
    int          dly_max    = 0;

    // reference and memory model state
    logic [31:0] exp_pc     = RESET_PC;
    logic        start_prev = 1'b0;
    logic        mem_pend   = 1'b0;
    logic [31:0] mem_addr   = 32'h0;
    int          mem_delay  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    int          busy_run   = 0;
    int          cyc        = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_req", req, 1'b0);
        check_eq("rst_addr", addr, RESET_PC);
        check_eq("rst_rready", rready, 1'b1);
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_busy", busy, 1'b1);
    endtask

    // One clock: drive at negedge, observe, then account for what the next posedge does
    task automatic tick();
        logic gfire;
        logic rfire;
        logic cons;
        @(negedge clk);
        start  = drv_start;
        hazard = drv_hazard;
        flush  = drv_flush & start_prev;
        target = drv_target;
        if (mem_pend && mem_delay == 0) begin
            rvalid = 1'b1;
            rdata  = mem_addr ^ KEY;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            if (mem_pend) mem_delay--;
        end
        case (gnt_mode)
            0:       gnt = ($urandom_range(0, 1) == 1);
            1:       gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
        #1;
        if (busy) begin
            check_eq("nop_when_empty", inst, 32'h0);
            check_eq("rready_when_empty", rready, 1'b1);
        end else begin
            check_eq("pc", pc, exp_pc);
            check_eq("inst", inst, exp_pc ^ KEY);
            if (hazard && !flush) check_eq("rready_on_hold", rready, 1'b0);
        end
        if (prev_stall && start_prev) begin
            check_eq("req_held", req, 1'b1);
            check_eq("addr_stable", addr, prev_addr);
        end
        if (busy && start && start_prev && !flush) busy_run++;
        else busy_run = 0;
        check_eq("liveness", (busy_run > 60), 1'b0);

        rfire = rvalid & rready;
        gfire = req & gnt;
        cons  = !busy && !hazard && !flush;
        if (rfire) mem_pend = 1'b0;
        if (gfire) begin
            check_eq("one_outstanding", mem_pend, 1'b0);
            mem_pend  = 1'b1;
            mem_addr  = addr;
            mem_delay = $urandom_range(dly_min, dly_max);
        end
        if (!start)     exp_pc = RESET_PC;
        else if (flush) exp_pc = target;
        else if (cons)  exp_pc = exp_pc + 32'd4;
        prev_stall = req & ~gnt;
        prev_addr  = addr;
        start_prev = start;
        cyc++;
    endtask

    task automatic wait_req(input int max);
        int i = 0;
        while (req !== 1'b1 && i < max) begin
            tick();
            i++;
        end
        check_eq("req_seen", req, 1'b1);
    endtask

    task automatic wait_valid(input int max);
        int i = 0;
        while (busy !== 1'b0 && i < max) begin
            tick();
            i++;
        end
        check_eq("valid_seen", busy, 1'b0);
    endtask

    initial begin
        int t0;
        logic seen_fc;
        logic saw_wrap;
        rst_n  = 1'b0;
        start  = 1'b0;
        hazard = 1'b0;
        flush  = 1'b0;
        target = 32'h0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        #12;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // zero-wait memory: first instruction after 3 edges, then one every 2
        gnt_mode = 1; dly_min = 0; dly_max = 0;
        tick(); tick();
        drv_start = 1'b1;
        t0 = cyc;
        tick();
        for (int i = 0; i < 10 && busy; i++) tick();
        check_eq("first_latency", cyc - 1 - t0, 3);
        check_eq("first_pc", pc, 32'h0);
        tick();
        check_eq("bubble", busy, 1'b1);
        tick();
        check_eq("second_pc", pc, 32'h4);
        tick();
        check_eq("bubble2", busy, 1'b1);

        // hold pc=8 for 5 cycles; pending 0xC waits in memory
        drv_hazard = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_pc", pc, 32'h8);
            check_eq("hold_busy", busy, 1'b0);
            if (i > 0) check_eq("hold_rready", rready, 1'b0);
        end
        drv_hazard = 1'b0;
        tick();
        check_eq("release_pc", pc, 32'h8);
        tick();
        check_eq("after_release_pc", pc, 32'hC);

        // flush in WAIT for 0x10
        check_eq("req_0x10", addr, 32'h10);
        drv_flush = 1'b1; drv_target = 32'h100;
        tick();
        drv_flush = 1'b0;
        tick();
        wait_req(10);
        check_eq("redirect_addr", addr, 32'h100);
        wait_valid(10);
        check_eq("redirect_pc", pc, 32'h100);

        // flush twice while REQ waits for a grant
        gnt_mode = 2;
        wait_req(10);
        drv_flush = 1'b1; drv_target = 32'h200;
        tick();
        drv_flush = 1'b0;
        tick();
        drv_flush = 1'b1; drv_target = 32'h300;
        tick();
        drv_flush = 1'b0;
        gnt_mode = 1;
        tick();
        wait_valid(20);
        check_eq("latest_target_pc", pc, 32'h300);

        // wrap at the top of the address space
        drv_flush = 1'b1; drv_target = 32'hFFFF_FFF8;
        tick();
        drv_flush = 1'b0;
        seen_fc  = 1'b0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!busy && pc == 32'hFFFF_FFFC) seen_fc = 1'b1;
            if (seen_fc && !busy && pc == 32'h0) saw_wrap = 1'b1;
        end
        check_eq("wrap_to_zero", saw_wrap, 1'b1);

        // start dropped in WAIT: one response drained, then idle
        dly_min = 2; dly_max = 2;
        wait_req(10);
        tick();
        drv_start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("stop_req", req, 1'b0);
        check_eq("stop_pc", pc, RESET_PC);
        check_eq("stop_busy", busy, 1'b1);
        check_eq("stop_drained", mem_pend, 1'b0);

        // async reset in the middle of a request
        dly_min = 0; dly_max = 0;
        drv_start = 1'b1;
        gnt_mode = 2;
        tick();
        wait_req(10);
        rst_n  = 1'b0;
        start  = 1'b0;
        gnt    = 1'b0;
        rvalid = 1'b0;
        #1;
        check_reset_vals();
        drv_start  = 1'b0;
        exp_pc     = RESET_PC;
        start_prev = 1'b0;
        mem_pend   = 1'b0;
        prev_stall = 1'b0;
        busy_run   = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        gnt_mode = 0; dly_min = 0; dly_max = 3;
        for (int i = 0; i < 3000; i++) begin
            drv_start  = ($urandom_range(0, 49) != 0);
            drv_hazard = ($urandom_range(0, 3) == 0);
            drv_flush  = ($urandom_range(0, 11) == 0);
            drv_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) drv_target = 32'hFFFF_FFF8;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
